// File: rtl/memory_bank_cfg_pkg.sv
// Shared types, defaults and helpers for the memory-bank bl/wl configuration writer.
// Optional parity checking on incoming words is enabled by defining MEMORY_BANK_CFG_PARITY_EN.
package memory_bank_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } mb_state_e;

  localparam int DEF_BL_WIDTH        = 4;
  localparam int DEF_WL_WIDTH        = 4;
  localparam int DEF_SETUP_CYCLES    = 1;
  localparam int DEF_WL_PULSE_CYCLES = 2;

`ifdef MEMORY_BANK_CFG_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Even parity: the parity bit equals the XOR of the data bits (zero padding is harmless).
  function automatic logic parity_f(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/memory_bank_wl_pulse_gen.sv
// SETUP/PULSE phase down-counter and one-hot word-line decode for the config writer.
module memory_bank_wl_pulse_gen
  import memory_bank_cfg_pkg::*;
#(
  parameter int WL_WIDTH        = DEF_WL_WIDTH,
  parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int WL_PULSE_CYCLES = DEF_WL_PULSE_CYCLES,
  parameter int ROW_W           = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_setup_i,
  input  logic             load_pulse_i,
  input  logic             pulse_en_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             cnt_zero_o,
  output logic [0:WL_WIDTH-1] wl_o
);

  localparam int MAXC = (SETUP_CYCLES > WL_PULSE_CYCLES) ? SETUP_CYCLES : WL_PULSE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_setup_i) begin
      cnt_d = CW'(SETUP_CYCLES - 1);
    end else if (load_pulse_i) begin
      cnt_d = CW'(WL_PULSE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero_o = (cnt_q == '0);

  // Decoded from registered state only, so wl never glitches off an input.
  for (genvar gi = 0; gi < WL_WIDTH; gi++) begin : g_wl
    assign wl_o[gi] = pulse_en_i && (row_i == ROW_W'(gi));
  end

endmodule

// File: rtl/memory_bank_config_writer.sv
// Memory-bank bl/wl writer: loads one row word per handshake and pulses its word line.
// Define MEMORY_BANK_CFG_PARITY_EN to add an even-parity bit on cfg_data and the sticky cfg_err.
module memory_bank_config_writer
  import memory_bank_cfg_pkg::*;
#(
  parameter int BL_WIDTH        = DEF_BL_WIDTH,
  parameter int WL_WIDTH        = DEF_WL_WIDTH,
  parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int WL_PULSE_CYCLES = DEF_WL_PULSE_CYCLES
) (
  input  logic                            prog_clk,
  input  logic                            global_resetn,
  input  logic                            start,
  input  logic                            cfg_abort,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [BL_WIDTH+PARITY_BITS-1:0] cfg_data,
  output logic [0:BL_WIDTH-1]             bl,
  output logic [0:WL_WIDTH-1]             wl,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int ROW_W = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;

  mb_state_e           state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic                load_setup, load_pulse, cnt_zero, par_ok;

`ifdef MEMORY_BANK_CFG_PARITY_EN
  logic err_q, err_d;
  assign par_ok  = (cfg_data[BL_WIDTH] == parity_f(64'(cfg_data[BL_WIDTH-1:0])));
  assign cfg_err = err_q;
`else
  assign par_ok  = 1'b1;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    bl_d       = bl_q;
    load_setup = 1'b0;
    load_pulse = 1'b0;
`ifdef MEMORY_BANK_CFG_PARITY_EN
    err_d      = err_q;
`endif
    if (cfg_abort) begin
      state_d = IDLE;
      bl_d    = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = LOAD;
            row_d   = '0;
`ifdef MEMORY_BANK_CFG_PARITY_EN
            err_d   = 1'b0;
`endif
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            if (par_ok) begin
              for (int i = 0; i < BL_WIDTH; i++) bl_d[i] = cfg_data[i];
              state_d    = SETUP;
              load_setup = 1'b1;
            end else begin
              // Corrupt word: drop the pass without ever raising a word line.
              bl_d    = '0;
              state_d = IDLE;
`ifdef MEMORY_BANK_CFG_PARITY_EN
              err_d   = 1'b1;
`endif
            end
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            state_d    = PULSE;
            load_pulse = 1'b1;
          end
        end
        PULSE: begin
          if (cnt_zero) state_d = HOLD;
        end
        HOLD: begin
          if (row_q == ROW_W'(WL_WIDTH - 1)) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!global_resetn) begin
      state_q <= IDLE;
      row_q   <= '0;
      bl_q    <= '0;
`ifdef MEMORY_BANK_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bl_q    <= bl_d;
`ifdef MEMORY_BANK_CFG_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  memory_bank_wl_pulse_gen #(
    .WL_WIDTH        (WL_WIDTH),
    .SETUP_CYCLES    (SETUP_CYCLES),
    .WL_PULSE_CYCLES (WL_PULSE_CYCLES),
    .ROW_W           (ROW_W)
  ) u_pulse_gen (
    .clk_i        (prog_clk),
    .rst_ni       (global_resetn),
    .load_setup_i (load_setup),
    .load_pulse_i (load_pulse),
    .pulse_en_i   (state_q == PULSE),
    .row_i        (row_q),
    .cnt_zero_o   (cnt_zero),
    .wl_o         (wl)
  );

  assign bl        = bl_q;
  assign cfg_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_memory_bank_config_writer.sv
// Directed bench for memory_bank_config_writer (default geometry plus a 1-row variant).
module tb_memory_bank_config_writer;

`ifdef MEMORY_BANK_CFG_PARITY_EN
  localparam int DW = 5;
`else
  localparam int DW = 4;
`endif

  logic          clk = 1'b0;
  logic          rstn, start, abort, valid;
  logic [DW-1:0] data;
  logic          ready, busy, done, err;
  logic [0:3]    bl, wl;

  logic          start1, abort1, valid1;
  logic [DW-1:0] data1;
  logic          ready1, busy1, done1, err1;
  logic [0:3]    bl1;
  logic [0:0]    wl1;

  int checks = 0;
  int errors = 0;

  logic [3:0] words [4];

  always #5 clk = ~clk;

  memory_bank_config_writer dut (
    .prog_clk(clk), .global_resetn(rstn), .start(start), .cfg_abort(abort),
    .cfg_valid(valid), .cfg_ready(ready), .cfg_data(data), .bl(bl), .wl(wl),
    .busy(busy), .done(done), .cfg_err(err)
  );

  memory_bank_config_writer #(
    .BL_WIDTH(4), .WL_WIDTH(1), .SETUP_CYCLES(3), .WL_PULSE_CYCLES(1)
  ) dut1 (
    .prog_clk(clk), .global_resetn(rstn), .start(start1), .cfg_abort(abort1),
    .cfg_valid(valid1), .cfg_ready(ready1), .cfg_data(data1), .bl(bl1), .wl(wl1),
    .busy(busy1), .done(done1), .cfg_err(err1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // bl[i] carries word bit i; bl is declared [0:3], so as a vector it reads bit-reversed.
  function automatic logic [3:0] blx(input logic [3:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[3-i] = w[i];
    return r;
  endfunction

  function automatic logic [3:0] onehot(input int r);
    return 4'b1000 >> r;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [3:0] w);
`ifdef MEMORY_BANK_CFG_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task step;
    @(posedge clk);
    #1;
  endtask

  task begin_pass;
    start = 1'b1;
    step;
    start = 1'b0;
    chk1("ready_after_start", ready, 1'b1);
    chk1("busy_after_start", busy, 1'b1);
  endtask

  // Entered in LOAD; leaves after the HOLD edge (back in LOAD or in DONE).
  task do_row(input int r, input logic [3:0] w, input logic poke_start);
    data  = mk(w);
    valid = 1'b1;
    chk1("ready_load", ready, 1'b1);
    chk4("wl_load", wl, 4'b0000);
    step;
    $display("row %0d word %b: bl=%b wl=%b", r, w, bl, wl);
    chk4("bl_setup", bl, blx(w));
    chk4("wl_setup", wl, 4'b0000);
    chk1("ready_setup", ready, 1'b0);
    if (poke_start) start = 1'b1;
    step;
    start = 1'b0;
    chk4("wl_pulse1", wl, onehot(r));
    chk4("bl_pulse1", bl, blx(w));
    step;
    chk4("wl_pulse2", wl, onehot(r));
    chk4("bl_pulse2", bl, blx(w));
    step;
    chk4("wl_hold", wl, 4'b0000);
    chk1("done_hold", done, 1'b0);
    step;
  endtask

  initial begin
    words[0] = 4'b1010; words[1] = 4'b0110; words[2] = 4'b1111; words[3] = 4'b0001;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    start1 = 1'b0; abort1 = 1'b0; valid1 = 1'b0; data1 = '0;
    step; step;

    // Reset state
    chk4("rst_bl", bl, 4'b0000);
    chk4("rst_wl", wl, 4'b0000);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    rstn = 1'b1;
    step;
    chk1("idle_ready", ready, 1'b0);

    // Full pass, valid held: done exactly 20 edges after the first handshake
    begin_pass;
    for (int r = 0; r < 4; r++) do_row(r, words[r], 1'b0);
    $display("pass1 end: done=%b busy=%b bl=%b", done, busy, bl);
    chk1("pass1_done", done, 1'b1);
    chk1("pass1_busy", busy, 1'b0);
    chk1("pass1_ready", ready, 1'b0);
    chk4("pass1_bl_retained", bl, blx(words[3]));
    chk4("pass1_wl", wl, 4'b0000);

    // Restart from DONE with a 3-cycle valid gap before row 2
    begin_pass;
    chk1("restart_done_clr", done, 1'b0);
    do_row(0, words[0], 1'b0);
    do_row(1, words[1], 1'b0);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      $display("gap cycle %0d: ready=%b wl=%b bl=%b", k, ready, wl, bl);
      chk1("gap_ready", ready, 1'b1);
      chk4("gap_wl", wl, 4'b0000);
      chk4("gap_bl", bl, blx(words[1]));
    end
    do_row(2, words[2], 1'b0);
    do_row(3, words[3], 1'b0);
    chk1("pass2_done", done, 1'b1);

    // Abort during the row-1 pulse
    begin_pass;
    do_row(0, words[0], 1'b0);
    data = mk(words[1]);
    step;
    step;
    chk4("abort_pre_wl", wl, onehot(1));
    abort = 1'b1;
    step;
    abort = 1'b0;
    valid = 1'b0;
    $display("abort: wl=%b bl=%b busy=%b done=%b", wl, bl, busy, done);
    chk4("abort_wl", wl, 4'b0000);
    chk4("abort_bl", bl, 4'b0000);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_ready", ready, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    step;
    start = 1'b0;
    abort = 1'b0;
    chk1("start_abort_busy", busy, 1'b0);
    chk1("start_abort_ready", ready, 1'b0);
    begin_pass;
    do_row(0, 4'b0101, 1'b0);
    abort = 1'b1;
    step;
    abort = 1'b0;
    valid = 1'b0;

    // Start pokes while busy are ignored; reset during SETUP of row 3
    begin_pass;
    for (int r = 0; r < 3; r++) do_row(r, words[r], 1'b1);
    data = mk(words[3]);
    valid = 1'b1;
    step;
    chk4("row3_bl_setup", bl, blx(words[3]));
    rstn = 1'b0;
    step;
    rstn = 1'b1;
    valid = 1'b0;
    $display("reset mid-pass: bl=%b wl=%b busy=%b ready=%b", bl, wl, busy, ready);
    chk4("midrst_bl", bl, 4'b0000);
    chk4("midrst_wl", wl, 4'b0000);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", ready, 1'b0);
    chk1("midrst_done", done, 1'b0);
    step;
    chk4("midrst_wl_after", wl, 4'b0000);
    chk1("midrst_busy_after", busy, 1'b0);

    // Single-row variant: SETUP_CYCLES=3, WL_PULSE_CYCLES=1
    start1 = 1'b1;
    step;
    start1 = 1'b0;
    chk1("v1_ready", ready1, 1'b1);
    data1  = mk(4'b0011);
    valid1 = 1'b1;
    step;
    valid1 = 1'b0;
    chk4("v1_bl", bl1, blx(4'b0011));
    chk1("v1_wl_e0", wl1[0], 1'b0);
    step;
    chk1("v1_wl_e1", wl1[0], 1'b0);
    step;
    chk1("v1_wl_e2", wl1[0], 1'b0);
    step;
    $display("v1 pulse: wl=%b bl=%b", wl1, bl1);
    chk1("v1_wl_e3", wl1[0], 1'b1);
    step;
    chk1("v1_wl_hold", wl1[0], 1'b0);
    chk1("v1_done_hold", done1, 1'b0);
    step;
    chk1("v1_done", done1, 1'b1);
    chk1("v1_busy", busy1, 1'b0);

`ifdef MEMORY_BANK_CFG_PARITY_EN
    // Bad parity: 1010 carries even parity 0, so a parity bit of 1 is corrupt
    begin_pass;
    data  = {1'b1, 4'b1010};
    valid = 1'b1;
    step;
    valid = 1'b0;
    $display("parity bad: err=%b busy=%b wl=%b bl=%b", err, busy, wl, bl);
    chk1("par_err", err, 1'b1);
    chk1("par_busy", busy, 1'b0);
    chk4("par_wl", wl, 4'b0000);
    chk4("par_bl", bl, 4'b0000);
    step;
    chk4("par_wl_after", wl, 4'b0000);
    chk1("par_err_sticky", err, 1'b1);
    begin_pass;
    chk1("par_err_cleared", err, 1'b0);
    abort = 1'b1;
    step;
    abort = 1'b0;
`else
    chk1("err_tied_low", err, 1'b0);
    chk1("err1_tied_low", err1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
